i2c_target_regfile: RTL
=======================

Name: i2c_target_regfile

Overview:
- I2C target (slave) peripheral exposing four 8-bit registers to an external I2C controller; the counterpart of the on-chip I2C controller side of the SoC.
- Lets the LM32 SoC be configured and read back by an external board-management controller.
- Fabric side gives parallel register contents, a write strobe, and a host write port so firmware can post status bytes for the external controller to read.

Parameters:
- DEV_ADDR, 7'h42, 7-bit I2C device address matched after START.
- RST_VAL, 32'h0000_0000, reset contents of the register file: reg0 = [7:0], reg3 = [31:24].

Ports:
- clk  in  1  system clock; must be at least 16× SCL frequency.
- reset  in  1  synchronous, active-high.
- scl_i  in  1  SCL pin input (asynchronous).
- sda_i  in  1  SDA pin input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA (open-drain, external pull-up).
- reg_q  out  32  register file contents; reg n = [8n+7:8n].
- i2c_wr_stb  out  1  one-clk pulse when an I2C data byte is written to a register.
- i2c_wr_idx  out  2  index of the register written; valid with i2c_wr_stb.
- busy  out  1  1 while this target is addressed, from address ACK until STOP, repeated START, or NACK.
- host_we  in  1  fabric write enable.
- host_idx  in  2  fabric write register index.
- host_dat  in  8  fabric write data.

Behaviour:
- Reset values: sda_oe = 0, reg_q = RST_VAL, i2c_wr_stb = 0, i2c_wr_idx = 0, busy = 0, pointer = 0, state = IDLE.
- Input path: scl_i and sda_i pass through a 2-FF synchroniser, then one edge-detect register.
  - Bus events are recognised 3 clk after the pin change.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and take priority over bit handling in the same clk.
- Bit timing: data is sampled on the SCL rising edge; sda_oe changes only on the SCL falling edge. SCL is never stretched.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB first (7-bit address + R/W).
    - Match → ACK: drive sda_oe = 1 from the falling edge after bit 8 to the next falling edge. Go to PTR if W, RD if R.
    - Mismatch → WAIT, no ACK.
  - PTR: receive 1 byte, pointer = byte[1:0], bits [7:2] ignored. ACK it, then go to WR.
  - WR: receive byte → reg[pointer] = byte; pulse i2c_wr_stb with i2c_wr_idx = pointer in the clk after the 8th rising edge. ACK it; pointer increments mod 4 (3 → 0).
  - RD:
    - At the falling edge ending the ACK clock, load reg[pointer]; drive sda_oe = ~bit, MSB first, changing on each falling edge.
    - After bit 8, release SDA at the falling edge and sample the controller ACK on the next rising edge.
    - ACK (SDA = 0): pointer++ mod 4, send the next byte.
    - NACK: go to WAIT with SDA released.
  - WAIT: ignore the bus until STOP (→ IDLE) or START (→ ADDR).
- STOP in any state: → IDLE, sda_oe = 0, busy = 0, pointer retained.
- Repeated START in any state: → ADDR, pointer retained, so write-pointer-then-read works.
- Host write: reg[host_idx] = host_dat on the next clk.
  - If an I2C write to the same index occurs in the same clk, the I2C write wins and the host write is dropped.
  - Writes to different indices both take effect.
- A read byte is latched when it is loaded for transmission; host writes during transmission affect only later reads.
- Reset mid-transfer: sda_oe released in the same clk as reset is sampled; all state returns to reset values; the bus stays ignored until the next START.
- General call (address 0) and 10-bit addressing are not supported; they are treated as mismatch.

Test Plan:
- Write 0x84, 0x01, 0xA5, 0x5A, STOP → address and pointer bytes ACKed; reg1 = 0xA5, reg2 = 0x5A; two i2c_wr_stb pulses with idx 1, then 2; busy low after STOP.
- Write 0x84, 0x03, Sr, 0x85, read 3 bytes with ACK, ACK, NACK → returns reg3, reg0, reg1 (pointer wraps 3 → 0); SDA released after NACK.
- Address 0x90 (mismatch) then 0x12 → sda_oe stays 0 for the whole transfer; no register changes; busy stays 0.
- host_we with idx 2, data 0x3C in the same clk as an I2C write of 0x77 to reg2 → reg2 = 0x77. Repeat with host idx 0 → reg0 = 0x3C and reg2 = 0x77.
- Reset asserted during the 5th bit of a read byte while sda_oe = 1 → sda_oe = 0 the next clk; reg_q = RST_VAL; a following full transaction works normally.
- STOP issued mid-byte in WR → no write strobe, state IDLE, partial byte discarded.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target exposing four 8-bit registers to an external controller, with a
// fabric-side host write port and per-byte write strobe.
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [31:0] reg_q,
  output logic        i2c_wr_stb,
  output logic [1:0]  i2c_wr_idx,
  output logic        busy,
  input  logic        host_we,
  input  logic [1:0]  host_idx,
  input  logic [7:0]  host_dat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PTR,
    S_WR,
    S_RD,
    S_WAIT
  } state_t;

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;

  state_t     r_state, w_state_nx;
  logic [3:0] r_bitcnt, w_bitcnt_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_ack, w_ack_nx;
  logic       r_sda_oe, w_sda_oe_nx;
  logic       r_busy, w_busy_nx;
  logic [1:0] r_ptr, w_ptr_nx;
  logic       r_rw, w_rw_nx;
  logic       r_wr_stb, w_wr_stb_nx;
  logic [1:0] r_wr_idx, w_wr_idx_nx;
  logic       w_i2c_we;

  logic [7:0] r_regs [4];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;
  logic [7:0] w_rx_byte, w_rd_byte;

  // Sync flops idle high so leaving reset never fakes a START on a quiet bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
  assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_rx_byte    = {r_shift[6:0], r_sda_s2};
  assign w_rd_byte    = r_regs[r_ptr];
  assign w_addr_match = (w_rx_byte[7:1] == DEV_ADDR) && (w_rx_byte[7:1] != 7'd0);

  always_comb begin
    w_state_nx  = r_state;
    w_bitcnt_nx = r_bitcnt;
    w_shift_nx  = r_shift;
    w_ack_nx    = r_ack;
    w_sda_oe_nx = r_sda_oe;
    w_busy_nx   = r_busy;
    w_ptr_nx    = r_ptr;
    w_rw_nx     = r_rw;
    w_wr_stb_nx = 1'b0;
    w_wr_idx_nx = r_wr_idx;
    w_i2c_we    = 1'b0;

    if (w_stop) begin
      w_state_nx  = S_IDLE;
      w_bitcnt_nx = 4'd0;
      w_ack_nx    = 1'b0;
      w_sda_oe_nx = 1'b0;
      w_busy_nx   = 1'b0;
    end else if (w_start) begin
      w_state_nx  = S_ADDR;
      w_bitcnt_nx = 4'd0;
      w_ack_nx    = 1'b0;
      w_sda_oe_nx = 1'b0;
      w_busy_nx   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WR: begin
          if (w_scl_rise && (r_bitcnt < 4'd8)) begin
            w_shift_nx  = w_rx_byte;
            w_bitcnt_nx = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              case (r_state)
                S_ADDR: begin
                  if (w_addr_match) w_rw_nx = w_rx_byte[0];
                  else w_state_nx = S_WAIT;
                end
                S_PTR: w_ptr_nx = w_rx_byte[1:0];
                default: begin
                  w_i2c_we    = 1'b1;
                  w_wr_stb_nx = 1'b1;
                  w_wr_idx_nx = r_ptr;
                  w_ptr_nx    = r_ptr + 2'd1;
                end
              endcase
            end
          end else if (w_scl_fall && r_ack) begin
            // End of our ACK clock: release SDA and move on to the next byte.
            w_ack_nx    = 1'b0;
            w_sda_oe_nx = 1'b0;
            w_bitcnt_nx = 4'd0;
            if (r_state == S_ADDR && r_rw) begin
              w_state_nx  = S_RD;
              w_shift_nx  = w_rd_byte;
              w_sda_oe_nx = ~w_rd_byte[7];
            end else if (r_state == S_ADDR) begin
              w_state_nx = S_PTR;
            end else begin
              w_state_nx = S_WR;
            end
          end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
            w_ack_nx    = 1'b1;
            w_sda_oe_nx = 1'b1;
            if (r_state == S_ADDR) w_busy_nx = 1'b1;
          end
        end
        S_RD: begin
          if (w_scl_rise) begin
            if (r_bitcnt < 4'd8) begin
              w_bitcnt_nx = r_bitcnt + 4'd1;
              w_shift_nx  = {r_shift[6:0], 1'b0};
            end else if (r_bitcnt == 4'd8) begin
              if (!r_sda_s2) begin
                w_ptr_nx    = r_ptr + 2'd1;
                w_bitcnt_nx = 4'd9;
              end else begin
                w_state_nx  = S_WAIT;
                w_busy_nx   = 1'b0;
                w_sda_oe_nx = 1'b0;
              end
            end
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd9) begin
              w_shift_nx  = w_rd_byte;
              w_sda_oe_nx = ~w_rd_byte[7];
              w_bitcnt_nx = 4'd0;
            end else if (r_bitcnt == 4'd8) begin
              w_sda_oe_nx = 1'b0;
            end else if (r_bitcnt != 4'd0) begin
              w_sda_oe_nx = ~r_shift[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_shift  <= 8'd0;
      r_ack    <= 1'b0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_ptr    <= 2'd0;
      r_rw     <= 1'b0;
      r_wr_stb <= 1'b0;
      r_wr_idx <= 2'd0;
    end else begin
      r_state  <= w_state_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_shift  <= w_shift_nx;
      r_ack    <= w_ack_nx;
      r_sda_oe <= w_sda_oe_nx;
      r_busy   <= w_busy_nx;
      r_ptr    <= w_ptr_nx;
      r_rw     <= w_rw_nx;
      r_wr_stb <= w_wr_stb_nx;
      r_wr_idx <= w_wr_idx_nx;
    end
  end

  // An I2C write to the same index beats a simultaneous host write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= RST_VAL[8*i +: 8];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_i2c_we && (r_ptr == 2'(i))) r_regs[i] <= w_rx_byte;
        else if (host_we && (host_idx == 2'(i))) r_regs[i] <= host_dat;
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign reg_q      = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign i2c_wr_stb = r_wr_stb;
  assign i2c_wr_idx = r_wr_idx;
  assign busy       = r_busy;

endmodule
